// File: rtl/switch_mcu_pkg.sv
// Shared types for the switch MCU execute unit: ALU op codes, execute FSM states, widths.
package switch_mcu_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned WT_CNT_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_MULH   = 4'd11,
        ALU_MULHSU = 4'd12,
        ALU_MULHU  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_RD   = 2'd1,
        EX_WT   = 2'd2,
        EX_WB   = 2'd3
    } ex_state_e;

endpackage

// File: rtl/switch_mcu_alu_core.sv
// Combinational integer ALU: (op, a, b) -> (result, illegal).
// The multiply group (codes 10-13) is built only when SWITCH_MCU_EX_MUL_EN is defined.
module switch_mcu_alu_core
    import switch_mcu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

`ifdef SWITCH_MCU_EX_MUL_EN
    // One 2*XLEN multiplier; the signedness of each operand is chosen by sign-extending it.
    logic              a_signed;
    logic              b_signed;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] product;

    always_comb begin
        a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
        b_signed = (op == ALU_MULH);
        a_ext    = {{XLEN{a_signed & a[XLEN-1]}}, a};
        b_ext    = {{XLEN{b_signed & b[XLEN-1]}}, b};
        product  = a_ext * b_ext;
    end
`endif

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
`ifdef SWITCH_MCU_EX_MUL_EN
            ALU_MUL:  result = product[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                      result = product[2*XLEN-1:XLEN];
`endif
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/switch_mcu_ex_alu.sv
// Execute unit: accept an op, read operands with RD_LAT read latency, write one result back.
// Multiply ops are available when SWITCH_MCU_EX_MUL_EN is defined (see switch_mcu_alu_core).
module switch_mcu_ex_alu
    import switch_mcu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned IMM_W   = 12,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_valid,
    output logic               out_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic               in_use_imm,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rs2,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_flush,
    output logic               out_ren_1,
    output logic [RADDR_W-1:0] out_raddr_1,
    input  logic [XLEN-1:0]    in_rdata_1,
    output logic               out_ren_2,
    output logic [RADDR_W-1:0] out_raddr_2,
    input  logic [XLEN-1:0]    in_rdata_2,
    output logic               out_wen,
    output logic [RADDR_W-1:0] out_waddr,
    output logic [XLEN-1:0]    out_wdata,
    output logic               out_done,
    output logic               out_err
);

    localparam int unsigned WT_INIT = (RD_LAT == 0) ? 0 : RD_LAT - 1;

    ex_state_e             state;
    ex_state_e             state_d;
    logic [WT_CNT_W-1:0]   cnt;
    logic [WT_CNT_W-1:0]   cnt_d;
    logic [OP_W-1:0]       op_q;
    logic                  use_imm_q;
    logic [IMM_W-1:0]      imm_q;
    logic [RADDR_W-1:0]    rd_q;
    logic                  accept;
    logic                  enter_wb;

    logic [XLEN-1:0]       opnd_b;
    logic [XLEN-1:0]       result;
    logic                  illegal;

    logic                  ren_1_d;
    logic [RADDR_W-1:0]    raddr_1_d;
    logic                  ren_2_d;
    logic [RADDR_W-1:0]    raddr_2_d;
    logic                  wen_d;
    logic [RADDR_W-1:0]    waddr_d;
    logic [XLEN-1:0]       wdata_d;
    logic                  done_d;
    logic                  err_d;

    assign out_ready = (state == EX_IDLE);
    assign accept    = (state == EX_IDLE) && in_valid && !in_flush;
    assign opnd_b    = use_imm_q ? XLEN'($signed(imm_q)) : in_rdata_2;

    switch_mcu_alu_core #(
        .XLEN    (XLEN)
    ) u_core (
        .op      (op_q),
        .a       (in_rdata_1),
        .b       (opnd_b),
        .result  (result),
        .illegal (illegal)
    );

    // Next state and next registered outputs; every output defaults to 0 outside its own cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        enter_wb  = 1'b0;
        ren_1_d   = 1'b0;
        raddr_1_d = '0;
        ren_2_d   = 1'b0;
        raddr_2_d = '0;
        wen_d     = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state)
            EX_IDLE: begin
                if (in_valid) begin
                    state_d   = EX_RD;
                    ren_1_d   = 1'b1;
                    raddr_1_d = in_rs1;
                    ren_2_d   = !in_use_imm;
                    raddr_2_d = in_use_imm ? '0 : in_rs2;
                end
            end
            EX_RD: begin
                if (RD_LAT > 0) begin
                    state_d = EX_WT;
                    cnt_d   = WT_CNT_W'(WT_INIT);
                end else begin
                    enter_wb = 1'b1;
                end
            end
            EX_WT: begin
                if (cnt == '0) begin
                    enter_wb = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            EX_WB: begin
                state_d = EX_IDLE;
            end
            default: begin
                state_d = EX_IDLE;
            end
        endcase

        // Operands are valid on this edge; the x0 write and illegal ops are suppressed.
        if (enter_wb) begin
            state_d = EX_WB;
            done_d  = 1'b1;
            err_d   = illegal;
            wen_d   = !illegal && (rd_q != '0);
            if (wen_d) begin
                waddr_d = rd_q;
                wdata_d = result;
            end
        end

        if (in_flush) begin
            state_d   = EX_IDLE;
            cnt_d     = '0;
            ren_1_d   = 1'b0;
            raddr_1_d = '0;
            ren_2_d   = 1'b0;
            raddr_2_d = '0;
            wen_d     = 1'b0;
            waddr_d   = '0;
            wdata_d   = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state       <= EX_IDLE;
            cnt         <= '0;
            op_q        <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            rd_q        <= '0;
            out_ren_1   <= 1'b0;
            out_raddr_1 <= '0;
            out_ren_2   <= 1'b0;
            out_raddr_2 <= '0;
            out_wen     <= 1'b0;
            out_waddr   <= '0;
            out_wdata   <= '0;
            out_done    <= 1'b0;
            out_err     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            if (accept) begin
                op_q      <= in_op;
                use_imm_q <= in_use_imm;
                imm_q     <= in_imm;
                rd_q      <= in_rd;
            end
            out_ren_1   <= ren_1_d;
            out_raddr_1 <= raddr_1_d;
            out_ren_2   <= ren_2_d;
            out_raddr_2 <= raddr_2_d;
            out_wen     <= wen_d;
            out_waddr   <= waddr_d;
            out_wdata   <= wdata_d;
            out_done    <= done_d;
            out_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_switch_mcu_ex_alu.sv
// Bench for switch_mcu_ex_alu: three instances (RD_LAT 0, 1, 3) against a behavioural ALU model.
module tb_switch_mcu_ex_alu;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        valid [3];
    logic        flush [3];
    logic [3:0]  op;
    logic        use_imm;
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    logic        ready  [3];
    logic        ren1   [3];
    logic [4:0]  raddr1 [3];
    logic [31:0] rdata1 [3];
    logic        ren2   [3];
    logic [4:0]  raddr2 [3];
    logic [31:0] rdata2 [3];
    logic        wen    [3];
    logic [4:0]  waddr  [3];
    logic [31:0] wdata  [3];
    logic        done   [3];
    logic        err    [3];

    logic [31:0] regs [32];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        switch_mcu_ex_alu #(
            .XLEN(32), .RADDR_W(5), .IMM_W(12), .RD_LAT(LAT)
        ) u_dut (
            .in_clk      (clk),
            .in_rst      (rst_n),
            .in_valid    (valid[g]),
            .out_ready   (ready[g]),
            .in_op       (op),
            .in_use_imm  (use_imm),
            .in_imm      (imm),
            .in_rs1      (rs1),
            .in_rs2      (rs2),
            .in_rd       (rd),
            .in_flush    (flush[g]),
            .out_ren_1   (ren1[g]),
            .out_raddr_1 (raddr1[g]),
            .in_rdata_1  (rdata1[g]),
            .out_ren_2   (ren2[g]),
            .out_raddr_2 (raddr2[g]),
            .in_rdata_2  (rdata2[g]),
            .out_wen     (wen[g]),
            .out_waddr   (waddr[g]),
            .out_wdata   (wdata[g]),
            .out_done    (done[g]),
            .out_err     (err[g])
        );

        // Register-file model: data is valid exactly LAT cycles after the read enable, junk otherwise.
        if (LAT == 0) begin : g_rf_comb
            assign rdata1[g] = ren1[g] ? regs[raddr1[g]] : JUNK;
            assign rdata2[g] = ren2[g] ? regs[raddr2[g]] : JUNK;
        end else begin : g_rf_pipe
            logic [4:0] a1 [LAT];
            logic [4:0] a2 [LAT];
            logic       v1 [LAT];
            logic       v2 [LAT];
            always @(posedge clk) begin
                a1[0] <= raddr1[g];
                a2[0] <= raddr2[g];
                v1[0] <= ren1[g];
                v2[0] <= ren2[g];
                for (int i = 1; i < LAT; i++) begin
                    a1[i] <= a1[i-1];
                    a2[i] <= a2[i-1];
                    v1[i] <= v1[i-1];
                    v2[i] <= v2[i-1];
                end
            end
            assign rdata1[g] = v1[LAT-1] ? regs[a1[LAT-1]] : JUNK;
            assign rdata2[g] = v2[LAT-1] ? regs[a2[LAT-1]] : JUNK;
        end
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    // Behavioural ALU on 64-bit integers, results truncated to 32 bits.
    function automatic logic [31:0] ref_alu(input int unsigned opc, input logic [31:0] a,
                                            input logic [31:0] b, output bit ill);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        int unsigned     sh;
        logic [31:0]     r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sh  = b % 32;
        r   = 32'd0;
        ill = 1'b0;
        case (opc)
            0:  r = 32'(ua + ub);
            1:  r = 32'(ua - ub);
            2:  r = 32'(ua << sh);
            3:  r = (sa < sb) ? 32'd1 : 32'd0;
            4:  r = (ua < ub) ? 32'd1 : 32'd0;
            5:  r = a ^ b;
            6:  r = 32'(ua >> sh);
            7:  r = 32'(sa >>> sh);
            8:  r = a | b;
            9:  r = a & b;
`ifdef SWITCH_MCU_EX_MUL_EN
            10: r = 32'(sa * sb);
            11: r = 32'((sa * sb) >>> 32);
            12: r = 32'((sa * longint'(ub)) >>> 32);
            13: r = 32'((ua * ub) >> 32);
`endif
            default: ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on instance g and check the read, latency, write-back and return to idle.
    task automatic run_op(input int g, input int unsigned opc, input bit ui, input logic [11:0] im,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                          input bit hold);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          ill;
        bit          exp_wen;
        bit          seen2;
        int          k;
        string       t;
        t = $sformatf("g%0d op%0d", g, opc);
        @(negedge clk);
        op = 4'(opc); use_imm = ui; imm = im; rs1 = r1; rs2 = r2; rd = rdd;
        valid[g] = 1'b1;
        chk({t, " ready_idle"}, 64'(ready[g]), 64'd1);
        @(posedge clk);
        a       = regs[r1];
        b       = ui ? {{20{im[11]}}, im} : regs[r2];
        res     = ref_alu(opc, a, b, ill);
        exp_wen = !ill && (rdd != 5'd0);
        k       = -1;
        seen2   = 1'b0;
        for (int c = 0; c <= 12 && k < 0; c++) begin
            @(negedge clk);
            if (!hold) valid[g] = 1'b0;
            if (c == 0) begin
                chk({t, " ren1"},   64'(ren1[g]),   64'd1);
                chk({t, " raddr1"}, 64'(raddr1[g]), 64'(r1));
                chk({t, " ren2"},   64'(ren2[g]),   64'(!ui));
                chk({t, " raddr2"}, 64'(raddr2[g]), ui ? 64'd0 : 64'(r2));
                chk({t, " busy"},   64'(ready[g]),  64'd0);
            end
            if (ren2[g]) seen2 = 1'b1;
            if (done[g]) k = c;
        end
        valid[g] = 1'b0;
        chk({t, " latency"}, 64'(k), 64'(1 + lat_of(g)));
        chk({t, " wen"},     64'(wen[g]),   64'(exp_wen));
        chk({t, " waddr"},   64'(waddr[g]), exp_wen ? 64'(rdd) : 64'd0);
        chk({t, " wdata"},   64'(wdata[g]), exp_wen ? 64'(res) : 64'd0);
        chk({t, " err"},     64'(err[g]),   64'(ill));
        if (ui) chk({t, " ren2_imm"}, 64'(seen2), 64'd0);
        @(negedge clk);
        chk({t, " ready_back"}, 64'(ready[g]), 64'd1);
        chk({t, " done_pulse"}, 64'(done[g]),  64'd0);
        chk({t, " no_reaccept"}, 64'(ren1[g]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        op = '0; use_imm = 1'b0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;
        for (int g = 0; g < 3; g++) begin
            valid[g] = 1'b0;
            flush[g] = 1'b0;
        end
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        regs[0] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[3] = 32'h8000_0000;
        regs[4] = 32'hFFFF_FFFF;
        regs[5] = 32'd1;
        regs[6] = 32'd0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("g%0d rst ready", g), 64'(ready[g]), 64'd1);
            chk($sformatf("g%0d rst ren1", g),  64'(ren1[g]),  64'd0);
            chk($sformatf("g%0d rst wen", g),   64'(wen[g]),   64'd0);
            chk($sformatf("g%0d rst wdata", g), 64'(wdata[g]), 64'd0);
            chk($sformatf("g%0d rst done", g),  64'(done[g]),  64'd0);
            chk($sformatf("g%0d rst err", g),   64'(err[g]),   64'd0);
        end
        rst_n = 1'b1;

        // Directed ops (RD_LAT=1 instance)
        run_op(1, 0,  1'b0, 12'h000, 5'd1, 5'd2, 5'd3, 1'b0);   // ADD 5+7
        run_op(1, 7,  1'b1, 12'hFFF, 5'd3, 5'd0, 5'd9, 1'b0);   // SRAI by 31
        run_op(1, 3,  1'b0, 12'h000, 5'd4, 5'd5, 5'd8, 1'b0);   // SLT
        run_op(1, 4,  1'b0, 12'h000, 5'd4, 5'd5, 5'd8, 1'b0);   // SLTU
        run_op(1, 1,  1'b0, 12'h000, 5'd6, 5'd5, 5'd8, 1'b0);   // SUB 0-1

        // Latency sweep with in_valid held while busy
        run_op(0, 0,  1'b0, 12'h000, 5'd1, 5'd2, 5'd7, 1'b1);
        run_op(2, 5,  1'b0, 12'h000, 5'd1, 5'd2, 5'd7, 1'b1);
        run_op(0, 8,  1'b1, 12'h123, 5'd1, 5'd0, 5'd7, 1'b0);
        run_op(2, 6,  1'b1, 12'h004, 5'd3, 5'd0, 5'd7, 1'b0);

        // x0 destination, illegal op, MULHU
        run_op(1, 0,  1'b0, 12'h000, 5'd1, 5'd2, 5'd0, 1'b0);
        run_op(1, 15, 1'b0, 12'h000, 5'd1, 5'd2, 5'd4, 1'b0);
        run_op(2, 13, 1'b0, 12'h000, 5'd4, 5'd4, 5'd4, 1'b0);

        // Random ops across all three latencies
        for (int n = 0; n < 40; n++) begin
            run_op($urandom_range(0, 2), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   12'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                   1'($urandom_range(0, 1)));
        end

        // Flush during WT on the RD_LAT=3 instance
        @(negedge clk);
        op = 4'd0; use_imm = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        valid[2] = 1'b1;
        @(negedge clk);
        valid[2] = 1'b0;
        @(negedge clk);
        flush[2] = 1'b1;
        @(negedge clk);
        flush[2] = 1'b0;
        chk("flush_wt ready", 64'(ready[2]), 64'd1);
        chk("flush_wt done",  64'(done[2]),  64'd0);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (wen[2] || done[2]) quiet = 1'b0;
        end
        chk("flush_wt no_write", 64'(quiet), 64'd1);

        // Flush beats a simultaneous accept in IDLE
        @(negedge clk);
        valid[1] = 1'b1;
        flush[1] = 1'b1;
        @(negedge clk);
        valid[1] = 1'b0;
        flush[1] = 1'b0;
        chk("flush_idle ren1",  64'(ren1[1]),  64'd0);
        chk("flush_idle ready", 64'(ready[1]), 64'd1);

        // Reset pulsed while in RD aborts at once
        @(negedge clk);
        valid[1] = 1'b1;
        @(negedge clk);
        valid[1] = 1'b0;
        chk("rst_rd ren1_before", 64'(ren1[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd ren1",  64'(ren1[1]),  64'd0);
        chk("rst_rd ready", 64'(ready[1]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (wen[1] || done[1]) quiet = 1'b0;
        end
        chk("rst_rd no_write", 64'(quiet), 64'd1);

        // Unit remains usable after flush and reset
        run_op(1, 9, 1'b0, 12'h000, 5'd4, 5'd2, 5'd10, 1'b0);
        run_op(2, 2, 1'b1, 12'h01F, 5'd5, 5'd0, 5'd11, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
